// File: rtl/prg_injector.sv
// -----------------------------------------------------------------------------
// prg_injector
//
// Injects a C64 PRG image from the SD loader byte stream into main RAM.
// Bytes 0/1 of the image are the little-endian load address; every later byte
// N is written to load_addr + N - 2 through a request/acknowledge DMA port.
// While a RAM write is outstanding the loader is stalled with ioctl_wait.
// When the download window closes the block reports the loaded range and
// pulses prg_done (or prg_err if the header never completed).
//
// Build option:
//   PRG_BASIC_PTR_EN  when defined, the end address is also patched into the
//                     $AE/$AF pointer, and for images loaded at BASIC_START
//                     into the BASIC pointers $2D/$2E, $2F/$30 and $31/$32.
//                     BASIC_START (default 16'h0801) exists only in that build.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   load_prg        loader has selected the PRG target
//   ioctl_download  download window active
//   ioctl_addr      byte index within the image
//   ioctl_data      image byte
//   ioctl_wr        one-cycle byte strobe
//   ioctl_wait      stall request back to the loader
//   ram_addr        C64 RAM write address
//   ram_dout        C64 RAM write data
//   ram_we          write request, held until ram_ack
//   ram_ack         one-cycle write acknowledge from the RAM arbiter
//   prg_start       latched load address
//   prg_end         exclusive end address (load_addr + payload length, mod 2^16)
//   prg_done        one-cycle pulse, injection complete
//   prg_err         one-cycle pulse, image shorter than two bytes
// -----------------------------------------------------------------------------
module prg_injector
`ifdef PRG_BASIC_PTR_EN
#(
   parameter logic [15:0] BASIC_START = 16'h0801
)
`endif
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load_prg,
   input  logic        ioctl_download,
   input  logic [22:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic        ioctl_wait,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_dout,
   output logic        ram_we,
   input  logic        ram_ack,
   output logic [15:0] prg_start,
   output logic [15:0] prg_end,
   output logic        prg_done,
   output logic        prg_err
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HDR      = 3'd1,
      ST_DATA     = 3'd2,
      ST_WR_WAIT  = 3'd3,
`ifdef PRG_BASIC_PTR_EN
      ST_PTR      = 3'd5,
      ST_PTR_WAIT = 3'd6,
`endif
      ST_DONE     = 3'd4
   } state_t;

`ifdef PRG_BASIC_PTR_EN
   // Pointer slots in write order. Slots 0..5 are the BASIC pointers and are
   // only visited for BASIC images; slots 6/7 ($AE/$AF) are always written.
   // Even slots take the low byte of prg_end, odd slots the high byte.
   function automatic logic [15:0] ptr_slot_addr(input logic [2:0] idx);
      logic [15:0] a;
      case (idx)
         3'd0:    a = 16'h002D;
         3'd1:    a = 16'h002E;
         3'd2:    a = 16'h002F;
         3'd3:    a = 16'h0030;
         3'd4:    a = 16'h0031;
         3'd5:    a = 16'h0032;
         3'd6:    a = 16'h00AE;
         3'd7:    a = 16'h00AF;
         default: a = 16'h00AE;
      endcase
      return a;
   endfunction
`endif

   state_t      state,      state_nxt;
   logic        act_prev,   act_prev_nxt;
   logic [7:0]  load_lo,    load_lo_nxt;
   logic [15:0] start_nxt,  end_nxt;
   logic [15:0] addr_nxt;
   logic [7:0]  dout_nxt;
   logic        we_nxt,     wait_nxt;
   logic        done_nxt,   err_nxt;
`ifdef PRG_BASIC_PTR_EN
   logic [2:0]  ptr_idx,    ptr_idx_nxt;
`endif

   logic        active;
   logic        accept;
   logic [15:0] data_addr;

   // Dropping either load_prg or ioctl_download ends the image, so both
   // qualify the window and every byte strobe.
   assign active    = ioctl_download & load_prg;
   assign accept    = ioctl_wr & active;
   assign data_addr = prg_start + (ioctl_addr[15:0] - 16'd2);

   // Next-state and next-output logic for the injection sequence.
   always_comb begin
      state_nxt    = state;
      act_prev_nxt = active;
      load_lo_nxt  = load_lo;
      start_nxt    = prg_start;
      end_nxt      = prg_end;
      addr_nxt     = ram_addr;
      dout_nxt     = ram_dout;
      we_nxt       = ram_we;
      wait_nxt     = ioctl_wait;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
`ifdef PRG_BASIC_PTR_EN
      ptr_idx_nxt  = ptr_idx;
`endif

      case (state)
         ST_IDLE: begin
            if (active && !act_prev) begin
               state_nxt   = ST_HDR;
               load_lo_nxt = 8'h00;
               start_nxt   = 16'h0000;
               end_nxt     = 16'h0000;
            end else begin
               state_nxt = ST_IDLE;
            end
         end

         ST_HDR: begin
            if (!active) begin
               // Window closed before the load address was complete.
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (accept && (ioctl_addr == 23'd0)) begin
               load_lo_nxt = ioctl_data;
            end else if (accept && (ioctl_addr == 23'd1)) begin
               // prg_end starts equal to prg_start so a header-only image
               // reports an empty range.
               start_nxt = {ioctl_data, load_lo};
               end_nxt   = {ioctl_data, load_lo};
               state_nxt = ST_DATA;
            end else begin
               state_nxt = ST_HDR;
            end
         end

         ST_DATA: begin
            if (!active) begin
`ifdef PRG_BASIC_PTR_EN
               state_nxt   = ST_PTR;
               ptr_idx_nxt = (prg_start == BASIC_START) ? 3'd0 : 3'd6;
`else
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
`endif
            end else if (accept) begin
               addr_nxt  = data_addr;
               dout_nxt  = ioctl_data;
               we_nxt    = 1'b1;
               wait_nxt  = 1'b1;
               end_nxt   = data_addr + 16'd1;
               state_nxt = ST_WR_WAIT;
            end else begin
               state_nxt = ST_DATA;
            end
         end

         ST_WR_WAIT: begin
            // Strobes arriving here break the loader contract and are dropped.
            if (ram_ack) begin
               we_nxt   = 1'b0;
               wait_nxt = 1'b0;
               if (!active) begin
`ifdef PRG_BASIC_PTR_EN
                  state_nxt   = ST_PTR;
                  ptr_idx_nxt = (prg_start == BASIC_START) ? 3'd0 : 3'd6;
`else
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  state_nxt = ST_DATA;
               end
            end else begin
               state_nxt = ST_WR_WAIT;
            end
         end

`ifdef PRG_BASIC_PTR_EN
         ST_PTR: begin
            // Pointer writes never stall the loader; ioctl_wait stays low.
            addr_nxt  = ptr_slot_addr(ptr_idx);
            dout_nxt  = ptr_idx[0] ? prg_end[15:8] : prg_end[7:0];
            we_nxt    = 1'b1;
            state_nxt = ST_PTR_WAIT;
         end

         ST_PTR_WAIT: begin
            if (ram_ack) begin
               we_nxt = 1'b0;
               if (ptr_idx == 3'd7) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end else begin
                  ptr_idx_nxt = ptr_idx + 3'd1;
                  state_nxt   = ST_PTR;
               end
            end else begin
               state_nxt = ST_PTR_WAIT;
            end
         end
`endif

         ST_DONE: begin
            // prg_done is high for exactly this cycle.
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
            we_nxt    = 1'b0;
            wait_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any pending write silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         act_prev   <= 1'b0;
         load_lo    <= 8'h00;
         prg_start  <= 16'h0000;
         prg_end    <= 16'h0000;
         ram_addr   <= 16'h0000;
         ram_dout   <= 8'h00;
         ram_we     <= 1'b0;
         ioctl_wait <= 1'b0;
         prg_done   <= 1'b0;
         prg_err    <= 1'b0;
`ifdef PRG_BASIC_PTR_EN
         ptr_idx    <= 3'd0;
`endif
      end else begin
         state      <= state_nxt;
         act_prev   <= act_prev_nxt;
         load_lo    <= load_lo_nxt;
         prg_start  <= start_nxt;
         prg_end    <= end_nxt;
         ram_addr   <= addr_nxt;
         ram_dout   <= dout_nxt;
         ram_we     <= we_nxt;
         ioctl_wait <= wait_nxt;
         prg_done   <= done_nxt;
         prg_err    <= err_nxt;
`ifdef PRG_BASIC_PTR_EN
         ptr_idx    <= ptr_idx_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_prg_injector.sv
// -----------------------------------------------------------------------------
// tb_prg_injector
//
// Drives PRG images through prg_injector, acknowledges RAM writes with a
// configurable or random latency, and compares every RAM write against a
// queue of expected writes built from the image (address = load address plus
// byte offset, pointer patches derived from the end address).
// -----------------------------------------------------------------------------
module tb_prg_injector;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_prg;
   logic        ioctl_download;
   logic [22:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        ioctl_wait;
   logic [15:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_we;
   logic        ram_ack;
   logic [15:0] prg_start;
   logic [15:0] prg_end;
   logic        prg_done;
   logic        prg_err;

   always #5 clk = ~clk;

   prg_injector dut (
      .clk            (clk),
      .reset          (reset),
      .load_prg       (load_prg),
      .ioctl_download (ioctl_download),
      .ioctl_addr     (ioctl_addr),
      .ioctl_data     (ioctl_data),
      .ioctl_wr       (ioctl_wr),
      .ioctl_wait     (ioctl_wait),
      .ram_addr       (ram_addr),
      .ram_dout       (ram_dout),
      .ram_we         (ram_we),
      .ram_ack        (ram_ack),
      .prg_start      (prg_start),
      .prg_end        (prg_end),
      .prg_done       (prg_done),
      .prg_err        (prg_err)
   );

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      bit          ptr;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] payload[$];

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int ack_mode;          // <0: random 0..3 cycles, otherwise fixed delay
   int done_cnt, err_cnt, we_seen, wait_bad;
   int done_cycle, last_ack_cycle;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic void push_exp(input logic [15:0] a, input logic [7:0] d, input bit p);
      wr_t e;
      e.a = a;
      e.d = d;
      e.ptr = p;
      exp_q.push_back(e);
   endfunction

   // RAM arbiter: acknowledges each request and scores the write at ack time.
   initial begin
      int wcnt;
      int target;
      bit acked;
      logic [15:0] a0;
      logic [7:0]  d0;
      wr_t e;
      wcnt = 0;
      target = 0;
      acked = 1'b0;
      ram_ack = 1'b0;
      forever begin
         @(negedge clk);
         ram_ack = 1'b0;
         if (ram_we === 1'b1) begin
            check("we_drop_after_ack", {31'd0, acked}, 32'd0);
            if (wcnt == 0) begin
               a0 = ram_addr;
               d0 = ram_dout;
               target = (ack_mode < 0) ? int'($urandom_range(3, 0)) : ack_mode;
            end else begin
               check("hold_addr", {16'd0, ram_addr}, {16'd0, a0});
               check("hold_data", {24'd0, ram_dout}, {24'd0, d0});
            end
            if (wcnt == target) begin
               ram_ack = 1'b1;
               acked = 1'b1;
               last_ack_cycle = cycle;
               check("write_expected", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("wr_addr", {16'd0, ram_addr}, {16'd0, e.a});
                  check("wr_data", {24'd0, ram_dout}, {24'd0, e.d});
                  check("wr_wait", {31'd0, ioctl_wait}, {31'd0, !e.ptr});
               end
            end
            wcnt++;
         end else begin
            wcnt = 0;
            acked = 1'b0;
         end
      end
   end

   // Pulse and handshake monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (prg_done === 1'b1) begin
            done_cnt++;
            done_cycle = cycle;
         end
         if (prg_err === 1'b1) err_cnt++;
         if (ram_we === 1'b1) we_seen++;
         if (ioctl_wait === 1'b1 && ram_we !== 1'b1) wait_bad++;
      end
   end

   task automatic clear_counts();
      @(posedge clk);
      done_cnt = 0;
      err_cnt = 0;
      we_seen = 0;
      wait_bad = 0;
      done_cycle = -1;
      last_ack_cycle = -100;
   endtask

   // One loader byte: honour ioctl_wait (bounded), strobe for one cycle.
   task automatic strobe(input logic [22:0] a, input logic [7:0] d);
      int guard;
      guard = 0;
      @(negedge clk);
      while (ioctl_wait === 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("wait_release_bound", {31'd0, guard < 64}, 32'd1);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (ioctl_wait === 1'b1 && guard < 64) begin
         @(negedge clk);
         guard++;
      end
      check("final_wait_bound", {31'd0, guard < 64}, 32'd1);
   endtask

   // Full image: header + payload, then close the window early or late.
   task automatic run_image(input logic [15:0] start, input bit drop_early, input bit end_by_prg);
      logic [15:0] pend;
      bit timing;
      int n;
      n = payload.size();
      clear_counts();
      exp_q.delete();
      for (int i = 0; i < n; i++) push_exp(start + 16'(i), payload[i], 1'b0);
      pend = start + 16'(n);
      timing = drop_early && (n > 0);
`ifdef PRG_BASIC_PTR_EN
      if (start == 16'h0801) begin
         for (int k = 0; k < 3; k++) begin
            push_exp(16'h002D + 16'(2 * k), pend[7:0], 1'b1);
            push_exp(16'h002E + 16'(2 * k), pend[15:8], 1'b1);
         end
      end
      push_exp(16'h00AE, pend[7:0], 1'b1);
      push_exp(16'h00AF, pend[15:8], 1'b1);
      timing = 1'b1;
`endif
      @(negedge clk);
      load_prg = 1'b1;
      ioctl_download = 1'b1;
      strobe(23'd0, start[7:0]);
      strobe(23'd1, start[15:8]);
      for (int i = 0; i < n; i++) strobe(23'(i + 2), payload[i]);
      if (!drop_early) begin
         wait_idle();
         repeat (2) @(negedge clk);
      end
      if (end_by_prg) load_prg = 1'b0;
      else ioctl_download = 1'b0;
      repeat (80) @(negedge clk);
      ioctl_download = 1'b0;
      load_prg = 1'b0;
      @(posedge clk);
      #1;
      check("prg_start", {16'd0, prg_start}, {16'd0, start});
      check("prg_end", {16'd0, prg_end}, {16'd0, pend});
      check("done_pulses", done_cnt, 1);
      check("err_pulses", err_cnt, 0);
      check("writes_left", exp_q.size(), 0);
      check("wait_without_we", wait_bad, 0);
      if (timing) check("done_after_last_ack", done_cycle - last_ack_cycle, 1);
   endtask

   initial begin
      reset = 1'b1;
      load_prg = 1'b0;
      ioctl_download = 1'b0;
      ioctl_addr = 23'd0;
      ioctl_data = 8'h00;
      ioctl_wr = 1'b0;
      ack_mode = 3;
      repeat (3) @(negedge clk);
      check("rst_ram_we", {31'd0, ram_we}, 32'd0);
      check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
      check("rst_ram_addr", {16'd0, ram_addr}, 32'd0);
      check("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      check("rst_start", {16'd0, prg_start}, 32'd0);
      check("rst_end", {16'd0, prg_end}, 32'd0);
      check("rst_done", {31'd0, prg_done}, 32'd0);
      check("rst_err", {31'd0, prg_err}, 32'd0);
      reset = 1'b0;

      // BASIC image 01 08 A9 00 60, ack three cycles after each request.
      payload.delete();
      payload.push_back(8'hA9);
      payload.push_back(8'h00);
      payload.push_back(8'h60);
      ack_mode = 3;
      run_image(16'h0801, 1'b0, 1'b0);
      check("basic_end_0804", {16'd0, prg_end}, 32'h0804);

      // Machine-code image at C000, window closes with a write pending.
      payload.delete();
      payload.push_back(8'h11);
      payload.push_back(8'h22);
      payload.push_back(8'h33);
      ack_mode = 1;
      run_image(16'hC000, 1'b1, 1'b0);

      // Address wrap past FFFF, same-cycle acknowledge.
      payload.delete();
      payload.push_back(8'hDE);
      payload.push_back(8'hAD);
      payload.push_back(8'hBE);
      payload.push_back(8'hEF);
      ack_mode = 0;
      run_image(16'hFFFE, 1'b1, 1'b0);
      check("wrap_end_0002", {16'd0, prg_end}, 32'h0002);

      // Header-only image, ended by load_prg dropping.
      payload.delete();
      ack_mode = -1;
      run_image(16'h1234, 1'b0, 1'b1);

      // Single-byte image: error pulse, no writes, no done.
      clear_counts();
      exp_q.delete();
      @(negedge clk);
      load_prg = 1'b1;
      ioctl_download = 1'b1;
      strobe(23'd0, 8'h01);
      ioctl_download = 1'b0;
      repeat (20) @(negedge clk);
      load_prg = 1'b0;
      @(posedge clk);
      #1;
      check("short_err", err_cnt, 1);
      check("short_done", done_cnt, 0);
      check("short_we", we_seen, 0);
      check("short_start_cleared", {16'd0, prg_start}, 32'd0);

      // Strobes without load_prg are ignored.
      clear_counts();
      @(negedge clk);
      ioctl_download = 1'b1;
      for (int i = 0; i < 4; i++) strobe(23'(i), 8'(8'h40 + i));
      ioctl_download = 1'b0;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      check("noprg_we", we_seen, 0);
      check("noprg_done", done_cnt, 0);
      check("noprg_err", err_cnt, 0);
      check("noprg_start", {16'd0, prg_start}, 32'd0);

      // Reset while a write is pending and the ack is withheld.
      clear_counts();
      exp_q.delete();
      ack_mode = 1000000;
      @(negedge clk);
      load_prg = 1'b1;
      ioctl_download = 1'b1;
      strobe(23'd0, 8'h00);
      strobe(23'd1, 8'h20);
      strobe(23'd2, 8'h5A);
      check("pend_we", {31'd0, ram_we}, 32'd1);
      check("pend_wait", {31'd0, ioctl_wait}, 32'd1);
      check("pend_addr", {16'd0, ram_addr}, 32'h2000);
      reset = 1'b1;
      ioctl_download = 1'b0;
      load_prg = 1'b0;
      @(negedge clk);
      check("rst_mid_we", {31'd0, ram_we}, 32'd0);
      check("rst_mid_wait", {31'd0, ioctl_wait}, 32'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1;
      check("rst_mid_done", done_cnt, 0);
      check("rst_mid_err", err_cnt, 0);
      ack_mode = -1;
      payload.delete();
      payload.push_back(8'h77);
      payload.push_back(8'h88);
      run_image(16'h4000, 1'b0, 1'b0);

      // Randomised images.
      for (int t = 0; t < 12; t++) begin
         int n;
         logic [15:0] st;
         n = int'($urandom_range(20, 0));
         st = ($urandom_range(3, 0) == 0) ? 16'h0801 : 16'($urandom);
         payload.delete();
         for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
         ack_mode = -1;
         run_image(st, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prg_injector.md
Name: prg_injector

Overview:
- Consumes the SD loader's byte stream while a PRG image is loading (ioctl_download with load_prg high) and writes the payload into C64 main RAM through a request/acknowledge DMA port.
- Bytes 0 and 1 form the little-endian load address; byte N≥2 is written to load_addr+N-2.
- Holds ioctl_wait high while a RAM write is outstanding.
- At end of download, reports the start/end range and, optionally, patches the KERNAL/BASIC end pointers.

Parameters:
- BASIC_START, 16'h0801, load address that qualifies an image as a BASIC program for pointer patching.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_prg  in  1  PRG target selected by loader
- ioctl_download  in  1  download window active
- ioctl_addr  in  23  byte index within image
- ioctl_data  in  8  image byte
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_wait  out  1  stall request to loader
- ram_addr  out  16  C64 RAM address
- ram_dout  out  8  RAM write data
- ram_we  out  1  write request, held until ack
- ram_ack  in  1  one-cycle write acknowledge from RAM arbiter
- prg_start  out  16  latched load address
- prg_end  out  16  exclusive end address = load_addr + payload_len (mod 2^16)
- prg_done  out  1  one-cycle pulse, injection complete
- prg_err  out  1  one-cycle pulse, image shorter than 2 bytes

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Reset mid-operation abandons any pending write: ram_we drops the cycle after reset is sampled, and no done/err pulse is issued.
- Byte acceptance: a byte is accepted only when ioctl_wr && ioctl_download && load_prg. Strobes with load_prg low are ignored entirely.
- State IDLE:
  - Rising ioctl_download with load_prg high → HDR; clears byte count and start/end registers.
- State HDR:
  - Accepted byte with ioctl_addr==0 → load_lo.
  - Accepted byte with ioctl_addr==1 → load_hi; prg_start <= {hi,lo}; → DATA.
- State DATA, on an accepted byte:
  - ram_addr <= prg_start + (ioctl_addr[15:0]-2); ram_dout <= ioctl_data.
  - ram_we <= 1 and ioctl_wait <= 1 in the following cycle (registered, 1-cycle latency); → WR_WAIT.
  - prg_end <= ram_addr+1, 16-bit wrap.
- State WR_WAIT:
  - Hold ram_we, ram_addr and ram_dout stable until ram_ack.
  - On ram_ack: ram_we <= 0, ioctl_wait <= 0 next cycle; → DATA.
  - Ack in the same cycle ram_we is first asserted is legal.
- Loader contract:
  - The loader issues no strobe while ioctl_wait is high. A violating strobe is dropped.
  - Minimum strobe spacing is 2 cycles.
- End of download (falling ioctl_download):
  - From HDR (fewer than 2 bytes received): prg_err pulse, no RAM writes → IDLE.
  - From DATA: → PTR (macro on) or DONE.
  - From WR_WAIT: finish the pending write first.
- Zero-payload image (exactly 2 bytes): prg_end = prg_start, no data writes, still completes normally.
- Payload over 64 KiB: addresses wrap modulo 2^16, with no error.
- State DONE: prg_done pulses for 1 cycle → IDLE.
- load_prg dropping mid-download is treated as the end of download.

Optional Feature:
- Macro PRG_BASIC_PTR_EN.
- Defined, state PTR:
  - Sequentially write the prg_end lo/hi pair to $AE/$AF (always).
  - If prg_start==BASIC_START, also write it to $2D/$2E, $2F/$30 and $31/$32.
  - Write order is ascending address.
  - Each write uses the same ram_we/ram_ack handshake; ioctl_wait stays 0.
  - prg_done pulses the cycle after the last ack.
- Undefined: no pointer writes, and DONE follows the last data ack directly.

Test Plan:
- Stream 01 08 A9 00 60 with ram_ack 3 cycles after each ram_we → writes $0801=A9, $0802=00, $0803=60; prg_start=0801, prg_end=0804; ioctl_wait high only during each write; one prg_done pulse.
- Same image with PRG_BASIC_PTR_EN → 8 extra writes: $2D=04, $2E=08, $2F=04, $30=08, $31=04, $32=08, $AE=04, $AF=08; prg_done after the $AF ack.
- Load address C000, 3 data bytes, macro on → only $AE=03, $AF=C0 are patched; $2D–$32 are untouched.
- Single-byte image (download drops after ioctl_addr 0) → prg_err pulse, zero ram_we, prg_done never asserted.
- Load address FFFE, 4 data bytes → writes at FFFE, FFFF, 0000, 0001; prg_end=0002.
- Assert reset while ram_we is high, ack withheld → ram_we=0 and ioctl_wait=0 next cycle; no prg_done; a subsequent new download loads correctly.
